// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 captures operands and decodes the opcode; S2 computes and registers result, flags and tag.
module alu_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v
);

  localparam int unsigned MSB = DATA_WIDTH - 1;
  localparam int unsigned KW  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    OP_LD   = 3'd0,
    OP_OUT  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_SHFL = 3'd7
  } op_e;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic [OP_WIDTH-1:0]   r_s1_op;
  logic [TAG_WIDTH-1:0]  r_s1_tag;

  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_z;
  logic                  r_c;
  logic                  r_v;

  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic                  w_in_xfer;
  op_e                   w_op;
  logic                  w_is_add;
  logic                  w_is_sub;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [KW-1:0]         w_k;
  logic [DATA_WIDTH-1:0] w_shfl;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_c;
  logic                  w_v;

  // Stall chain: a stage may advance when it is empty or its successor advances.
  assign w_s2_adv  = ~r_s2_valid | out_ready;
  assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
  assign in_ready  = w_s1_adv & ~rst;
  assign w_in_xfer = in_valid & w_s1_adv;

  assign w_op     = op_e'(r_s1_op);
  assign w_is_add = (w_op == OP_ADD);
  assign w_is_sub = (w_op == OP_SUB);

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  // Lowest set bit of B wins; k is its 1-based position (DATA_WIDTH shifts everything out).
  always_comb begin
    w_k = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (r_s1_b[i]) w_k = KW'(i + 1);
    end
  end

  assign w_shfl = (r_s1_b == '0) ? r_s1_a : (r_s1_a << w_k);

  always_comb begin
    w_res = r_s1_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_LD, OP_OUT: w_res = r_s1_a;
      OP_ADD:  w_res = w_sum[MSB:0];
      OP_SUB:  w_res = w_diff[MSB:0];
      OP_NAND: w_res = ~(r_s1_a & r_s1_b);
      OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_SHFL: w_res = w_shfl;
      default: w_res = r_s1_a;
    endcase
    if (w_is_add) begin
      w_c = w_sum[DATA_WIDTH];
      w_v = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
    end else if (w_is_sub) begin
      w_c = w_diff[DATA_WIDTH];
      w_v = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
    end
  end

  // Valid bits: reset and flush both empty the pipe; flush blocks any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_op  <= '0;
      r_s1_tag <= '0;
    end else if (!flush && w_in_xfer) begin
      r_s1_a   <= A;
      r_s1_b   <= B;
      r_s1_op  <= op;
      r_s1_tag <= in_tag;
    end
  end

  // Output registers only load on a real S1->S2 move, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_tag    <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else if (!flush && w_s2_adv && r_s1_valid) begin
      r_result <= w_res;
      r_tag    <= r_s1_tag;
      r_z      <= (w_res == '0);
      r_c      <= w_c;
      r_v      <= w_v;
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign out_tag   = r_tag;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, random ops under backpressure,
// and hand-written stall, reset and flush sequences, all checked through a scoreboard.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] tag;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_i;
  logic [3:0] tag_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] out_tag;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t cur_exp;
  bit   acc;
  bit   bp_rand = 1'b0;

  alu_pipe #(.DATA_WIDTH(8), .OP_WIDTH(3), .TAG_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_i),
    .B        (b_i),
    .op       (op_i),
    .in_tag   (tag_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent reference written with integer arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] t);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb_ = int'($signed(b));
    int r = 0;
    int s = 0;
    int k = 0;
    e = '0;
    case (o)
      3'd2: begin r = ua + ub; e.c = (r > 255); s = sa + sb_; e.v = (s > 127) || (s < -128); end
      3'd3: begin r = ua - ub; e.c = (ua < ub); s = sa - sb_; e.v = (s > 127) || (s < -128); end
      3'd4: r = int'(~(a & b));
      3'd5: r = int'(~(a | b));
      3'd6: r = int'(a ^ b);
      3'd7: begin
        if (b == 8'h00) r = ua;
        else begin
          for (int i = 7; i >= 0; i--) if (b[i]) k = i + 1;
          r = (k >= 8) ? 0 : (ua << k);
        end
      end
      default: r = ua;
    endcase
    e.res = 8'(r);
    e.z   = (e.res == 8'h00);
    e.tag = t;
    return e;
  endfunction

  // One cycle: account for handshakes seen before the edge, then step to just after it.
  task automatic tick();
    exp_t e;
    #1;
    acc = 1'b0;
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected: got tag %0h expected no output", out_tag);
        end else begin
          e = sb.pop_front();
          chk("sb_result", 32'({result, out_tag, flag_z, flag_c, flag_v}), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] t, input exp_t e);
    op_i = o; a_i = a; b_i = b; tag_i = t; cur_exp = e; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL send_timeout: tag %0h got no in_ready expected accept", t);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) return;
      out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
    end
    n_chk++;
    n_err++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = '{3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{3'd3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{3'd7, 8'h03, 8'h04, 8'h18, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{3'd7, 8'h03, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{3'd7, 8'h03, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{3'd7, 8'h03, 8'h01, 8'h06, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{3'd0, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{3'd1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{3'd4, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0};
    vt[10] = '{3'd5, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0};
    vt[11] = '{3'd6, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[12] = '{3'd3, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vt[13] = '{3'd2, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vt[14] = '{3'd3, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; op_i = '0; tag_i = '0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({out_valid, result, out_tag, flag_z, flag_c, flag_v}), 32'h0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Directed table, back-to-back at full throughput.
    for (int i = 0; i < 15; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, 4'(i),
           '{vt[i].res, 4'(i), vt[i].z, vt[i].c, vt[i].v});
    end
    drain();

    // Random ops with random backpressure.
    bp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      logic [7:0] a;
      logic [7:0] b;
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(o, a, b, 4'(i), model(o, a, b, 4'(i)));
    end
    drain();
    bp_rand = 1'b0;

    // Backpressure: two ops fill the pipe, the third waits.
    out_ready = 1'b0;
    send(3'd2, 8'h10, 8'h20, 4'd1, '{8'h30, 4'd1, 1'b0, 1'b0, 1'b0});
    send(3'd2, 8'h01, 8'h02, 4'd2, '{8'h03, 4'd2, 1'b0, 1'b0, 1'b0});
    op_i = 3'd3; a_i = 8'h05; b_i = 8'h07; tag_i = 4'd3; in_valid = 1'b1;
    cur_exp = '{8'hFE, 4'd3, 1'b0, 1'b1, 1'b0};
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    for (int n = 0; n < 2; n++) begin
      chk("bp_hold_out", 32'({out_valid, result, out_tag}), 32'({1'b1, 8'h30, 4'd1}));
      tick();
      chk("bp_still_blocked", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    send(3'd3, 8'h05, 8'h07, 4'd3, '{8'hFE, 4'd3, 1'b0, 1'b1, 1'b0});
    drain();

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(3'd0, 8'h11, 8'h00, 4'd9, model(3'd0, 8'h11, 8'h00, 4'd9));
    send(3'd0, 8'h22, 8'h00, 4'd10, model(3'd0, 8'h22, 8'h00, 4'd10));
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({out_valid, result, out_tag, flag_z, flag_c, flag_v}), 32'h0);
    sb.delete();
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd2, 8'h22, 8'h11, 4'd11, '{8'h33, 4'd11, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0;
    chk("lat_cycle1_valid", 32'(out_valid), 32'h0);
    tick();
    chk("lat_cycle2_out", 32'({out_valid, result, out_tag}), 32'({1'b1, 8'h33, 4'd11}));
    drain();

    // Flush beats stall: both in-flight ops discarded.
    out_ready = 1'b0;
    send(3'd6, 8'h0F, 8'hF0, 4'd12, model(3'd6, 8'h0F, 8'hF0, 4'd12));
    send(3'd6, 8'h01, 8'h02, 4'd13, model(3'd6, 8'h01, 8'h02, 4'd13));
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);

    // Flush cycle ignores in_valid even with in_ready high.
    out_ready = 1'b1;
    send(3'd0, 8'h44, 8'h00, 4'd14, model(3'd0, 8'h44, 8'h00, 4'd14));
    op_i = 3'd0; a_i = 8'h55; tag_i = 4'd15; in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop_valid", 32'(out_valid), 32'h0);
    tick();
    chk("flush_ignored_in", 32'(out_valid), 32'h0);
    tick();
    chk("flush_sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
